// File: rtl/serial_magnitude_accumulator_if.sv
// Handshake and result bundle between the bit-serial comparator front end and the accumulator.
// Ports: start/in_valid/in_eq/in_l/in_g flow from upstream; in_ready/busy/done/res_*/err/bits_seen flow back.
// master = upstream driver (shifter + one_bit_comparator), slave = serial_magnitude_accumulator.
interface serial_magnitude_accumulator_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             start;
    logic             in_valid;
    logic             in_eq;
    logic             in_l;
    logic             in_g;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             res_eq;
    logic             res_l;
    logic             res_g;
    logic             err;
    logic [CNT_W-1:0] bits_seen;

    modport master (
        output start, in_valid, in_eq, in_l, in_g,
        input  in_ready, busy, done, res_eq, res_l, res_g, err, bits_seen
    );

    modport slave (
        input  start, in_valid, in_eq, in_l, in_g,
        output in_ready, busy, done, res_eq, res_l, res_g, err, bits_seen
    );
endinterface

// File: rtl/serial_magnitude_accumulator.sv
// Purpose: folds MSB-first per-bit eq/l/g flags into one registered WIDTH-bit magnitude verdict.
// Latency: done pulses the cycle after the WIDTH-th accepted bit; minimum start-to-start period WIDTH+2.
// Backpressure: in_ready is high only in RUN (decoded from registered state); in_valid gaps stretch the run.
// Ports: clk, rst (sync, active-high); bus (slave) carries start, in_* bit flags, in_ready, busy, done,
//        res_eq/res_l/res_g verdict, sticky err for non-one-hot bits, and bits_seen counter.
module serial_magnitude_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_magnitude_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic             decided;
    logic             res_eq;
    logic             res_l;
    logic             res_g;
    logic             err;
    logic [CNT_W-1:0] bits_seen;

    logic accept;
    logic one_hot;
    logic decide_l;
    logic decide_g;
    logic last_bit;

    assign accept   = (state == S_RUN) & bus.in_valid;
    // Exactly one flag set: odd parity rules out the two-flag cases, the AND rules out all three.
    assign one_hot  = (bus.in_eq ^ bus.in_l ^ bus.in_g) & ~(bus.in_eq & bus.in_l & bus.in_g);
    assign decide_l = accept & ~decided & one_hot & bus.in_l;
    assign decide_g = accept & ~decided & one_hot & bus.in_g;
    assign last_bit = accept & (bits_seen == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            decided   <= 1'b0;
            res_eq    <= 1'b0;
            res_l     <= 1'b0;
            res_g     <= 1'b0;
            err       <= 1'b0;
            bits_seen <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_RUN;
                        decided   <= 1'b0;
                        res_eq    <= 1'b0;
                        res_l     <= 1'b0;
                        res_g     <= 1'b0;
                        err       <= 1'b0;
                        bits_seen <= '0;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        bits_seen <= bits_seen + 1'b1;
                        if (!one_hot) begin
                            err <= 1'b1;
                        end
                        if (decide_l) begin
                            res_l   <= 1'b1;
                            decided <= 1'b1;
                        end
                        if (decide_g) begin
                            res_g   <= 1'b1;
                            decided <= 1'b1;
                        end
                        // Include a decision made by this final bit so the verdict stays one-hot.
                        if (last_bit) begin
                            state  <= S_DONE;
                            res_eq <= ~(decided | decide_l | decide_g);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_RUN);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.res_eq    = res_eq;
    assign bus.res_l     = res_l;
    assign bus.res_g     = res_g;
    assign bus.err       = err;
    assign bus.bits_seen = bits_seen;
endmodule
